// File: rtl/spi_reg_bank.sv
// Command decoder behind an SPI slave: frames of {cmd[, data]} read or write a register bank.
// The top register slot is the read-only hw_status. The response is held on tx_data until the next frame.
module spi_reg_bank #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   cs_n,
   input  logic                                   rx_valid,
   input  logic [DATA_WIDTH-1:0]                  rx_data,
   input  logic [DATA_WIDTH-1:0]                  hw_status,
   output logic [DATA_WIDTH-1:0]                  tx_data,
   output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]  regs,
   output logic                                   wr_strobe,
   output logic [ADDR_WIDTH-1:0]                  wr_addr,
   output logic                                   proto_err
);
   localparam int NUM_REGS = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(NUM_REGS-1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CMD   = 2'd1,
      S_WDATA = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    r_cs_sync1;
   logic                    r_cs_sync2;
   logic                    r_cs_d;
   logic                    r_rx_valid_d;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic                    r_extra_seen;
   logic [DATA_WIDTH-1:0]   r_tx;
   logic                    r_wr_strobe;
   logic [ADDR_WIDTH-1:0]   r_wr_addr;
   logic                    r_proto_err;
   logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];

   logic                    w_frame_start;
   logic                    w_frame_end;
   logic                    w_byte_ev;
   logic [ADDR_WIDTH-1:0]   w_cmd_addr;
   logic [DATA_WIDTH-1:0]   w_rd_val;
   logic                    w_latch_addr;
   logic                    w_rd_load;
   logic                    w_wr_en;
   logic                    w_err;
   logic                    w_extra_set;
   logic                    w_extra_clr;

   assign w_frame_start = ~r_cs_sync2 &  r_cs_d;
   assign w_frame_end   =  r_cs_sync2 & ~r_cs_d;
   assign w_byte_ev     =  rx_valid & ~r_rx_valid_d;
   assign w_cmd_addr    =  rx_data[ADDR_WIDTH-1:0];
   assign w_rd_val      = (w_cmd_addr == STATUS_ADDR) ? hw_status : r_regs[w_cmd_addr];

   // A new frame_start always wins: it discards whatever partial transaction was in flight.
   always_comb begin
      w_state_nxt  = r_state;
      w_latch_addr = 1'b0;
      w_rd_load    = 1'b0;
      w_wr_en      = 1'b0;
      w_err        = 1'b0;
      w_extra_set  = 1'b0;
      w_extra_clr  = 1'b0;
      if (w_frame_start) begin
         w_state_nxt = S_CMD;
         w_extra_clr = 1'b1;
      end else begin
         if (w_byte_ev) begin
            case (r_state)
               S_CMD: begin
                  if (rx_data[DATA_WIDTH-1]) begin
                     w_latch_addr = 1'b1;
                     w_state_nxt  = S_WDATA;
                  end else begin
                     w_rd_load    = 1'b1;
                     w_state_nxt  = S_DONE;
                  end
               end
               S_WDATA: begin
                  if (r_addr == STATUS_ADDR) begin
                     w_err   = 1'b1;
                  end else begin
                     w_wr_en = 1'b1;
                  end
                  w_state_nxt = S_DONE;
               end
               S_DONE: begin
                  if (!r_extra_seen) begin
                     w_err       = 1'b1;
                     w_extra_set = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         // A byte landing on the same clk as frame_end completes the write, so it is no abort.
         if (w_frame_end) begin
            if (r_state == S_WDATA && !w_byte_ev) begin
               w_err = 1'b1;
            end
            w_state_nxt = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cs_sync1   <= 1'b1;
         r_cs_sync2   <= 1'b1;
         r_cs_d       <= 1'b1;
         r_rx_valid_d <= 1'b0;
         r_state      <= S_IDLE;
         r_addr       <= '0;
         r_extra_seen <= 1'b0;
         r_tx         <= '0;
         r_wr_strobe  <= 1'b0;
         r_wr_addr    <= '0;
         r_proto_err  <= 1'b0;
         for (int k = 0; k < NUM_REGS; k++) begin
            r_regs[k] <= '0;
         end
      end else begin
         r_cs_sync1   <= cs_n;
         r_cs_sync2   <= r_cs_sync1;
         r_cs_d       <= r_cs_sync2;
         r_rx_valid_d <= rx_valid;
         r_state      <= w_state_nxt;
         r_wr_strobe  <= w_wr_en;
         r_proto_err  <= w_err;
         if (w_latch_addr) begin
            r_addr <= w_cmd_addr;
         end
         if (w_extra_clr) begin
            r_extra_seen <= 1'b0;
         end else if (w_extra_set) begin
            r_extra_seen <= 1'b1;
         end
         if (w_rd_load) begin
            r_tx <= w_rd_val;
         end
         if (w_wr_en) begin
            r_regs[r_addr] <= rx_data;
            r_tx           <= rx_data;
            r_wr_addr      <= r_addr;
         end
      end
   end

   // The status slot has no storage behind it on the flattened output.
   for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
      if (k == NUM_REGS-1) begin : g_status
         assign regs[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else begin : g_ctrl
         assign regs[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[k];
      end
   end

   assign tx_data   = r_tx;
   assign wr_strobe = r_wr_strobe;
   assign wr_addr   = r_wr_addr;
   assign proto_err = r_proto_err;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed frame table, hand-written edge cases, then random frames vs a frame-level model.
module tb_spi_reg_bank;
   localparam int NR = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cs_n = 1'b1;
   logic         rx_valid = 1'b0;
   logic [7:0]   rx_data = 8'h00;
   logic [7:0]   hw_status = 8'h00;
   logic [7:0]   tx_data;
   logic [127:0] regs;
   logic         wr_strobe;
   logic [3:0]   wr_addr;
   logic         proto_err;

   always #5 clk = ~clk;

   spi_reg_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rx_valid(rx_valid), .rx_data(rx_data),
      .hw_status(hw_status), .tx_data(tx_data), .regs(regs), .wr_strobe(wr_strobe),
      .wr_addr(wr_addr), .proto_err(proto_err)
   );

   int n_checks = 0;
   int n_errors = 0;
   int strobe_cnt = 0;
   int err_cnt = 0;
   logic [3:0] last_wa = 4'h0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_strobe) begin
            strobe_cnt++;
            last_wa = wr_addr;
         end
         if (proto_err) err_cnt++;
      end
   end

   // Frame-level reference: what a whole cs_n-low frame of n bytes does to the bank.
   logic [7:0] m_regs [NR];
   logic [7:0] m_tx;

   task automatic model_reset();
      for (int k = 0; k < NR; k++) m_regs[k] = 8'h00;
      m_tx = 8'h00;
   endtask

   task automatic model_frame(input int n, input logic [31:0] by, input logic [7:0] hw,
                              output int es, output int ee);
      logic [7:0] c;
      logic [7:0] d;
      int a;
      es = 0;
      ee = 0;
      c = by[31:24];
      d = by[23:16];
      a = int'(c) % NR;
      if (n == 0) return;
      if (c[7] == 1'b0) begin
         m_tx = (a == NR-1) ? hw : m_regs[a];
         if (n > 1) ee = 1;
      end else if (n == 1) begin
         ee = 1;
      end else if (a == NR-1) begin
         ee = (n > 2) ? 2 : 1;
      end else begin
         m_regs[a] = d;
         m_tx = d;
         es = 1;
         if (n > 2) ee = 1;
      end
   endtask

   function automatic logic [127:0] model_vec();
      logic [127:0] v;
      v = '0;
      for (int k = 0; k < NR-1; k++) v[k*8 +: 8] = m_regs[k];
      return v;
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rx_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic drive_frame(input int n, input logic [31:0] by, input logic [7:0] hw);
      hw_status = hw;
      strobe_cnt = 0;
      err_cnt = 0;
      cs_n = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      for (int i = 0; i < n; i++) send_byte(by[31-8*i -: 8]);
      cs_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
   endtask

   typedef struct {
      int          n;
      logic [31:0] by;
      logic [7:0]  hw;
      logic [7:0]  tx;
      int          st;
      int          er;
      int          ra;
      logic [7:0]  rv;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int es;
      int ee;
      int n;
      logic [31:0] by;
      logic [7:0] hw;

      tbl[0] = '{2, 32'h83A50000, 8'h00, 8'hA5, 1, 0, 3,  8'hA5};
      tbl[1] = '{2, 32'h843C0000, 8'h00, 8'h3C, 1, 0, 4,  8'h3C};
      tbl[2] = '{1, 32'h03000000, 8'h00, 8'hA5, 0, 0, 3,  8'hA5};
      tbl[3] = '{0, 32'h00000000, 8'h00, 8'hA5, 0, 0, 3,  8'hA5};
      tbl[4] = '{1, 32'h0F000000, 8'h5C, 8'h5C, 0, 0, 15, 8'h00};
      tbl[5] = '{2, 32'h8F110000, 8'h5C, 8'h5C, 0, 1, 15, 8'h00};
      tbl[6] = '{1, 32'h85000000, 8'h5C, 8'h5C, 0, 1, 5,  8'h00};
      tbl[7] = '{4, 32'h82123456, 8'h5C, 8'h12, 1, 1, 2,  8'h12};

      model_reset();
      #2;
      check("reset_regs", regs, 128'h0);
      check("reset_tx", tx_data, 8'h00);
      check("reset_strobe", wr_strobe, 1'b0);
      check("reset_err", proto_err, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) begin
         drive_frame(tbl[i].n, tbl[i].by, tbl[i].hw);
         model_frame(tbl[i].n, tbl[i].by, tbl[i].hw, es, ee);
         check($sformatf("tbl%0d_tx", i), tx_data, tbl[i].tx);
         check($sformatf("tbl%0d_strobes", i), strobe_cnt, tbl[i].st);
         check($sformatf("tbl%0d_errs", i), err_cnt, tbl[i].er);
         check($sformatf("tbl%0d_reg", i), regs[tbl[i].ra*8 +: 8], tbl[i].rv);
         if (tbl[i].st > 0) check($sformatf("tbl%0d_wr_addr", i), last_wa, tbl[i].ra);
      end
      check("tbl_all_regs", regs, model_vec());

      // Data byte arrives on the very clk that frame_end is seen: a completed write, no error.
      strobe_cnt = 0;
      err_cnt = 0;
      cs_n = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      send_byte(8'h86);
      rx_data = 8'h99;
      cs_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rx_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rx_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      m_regs[6] = 8'h99;
      m_tx = 8'h99;
      check("simul_reg6", regs[6*8 +: 8], 8'h99);
      check("simul_strobes", strobe_cnt, 1);
      check("simul_errs", err_cnt, 0);

      // Reset in the middle of a write frame.
      cs_n = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      send_byte(8'h81);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_regs", regs, 128'h0);
      check("midrst_tx", tx_data, 8'h00);
      cs_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      drive_frame(2, 32'h817E0000, 8'h00);
      model_frame(2, 32'h817E0000, 8'h00, es, ee);
      check("postrst_reg1", regs[1*8 +: 8], 8'h7E);
      check("postrst_strobes", strobe_cnt, 1);
      check("postrst_wr_addr", last_wa, 4'd1);
      check("postrst_regs", regs, model_vec());

      for (int i = 0; i < 40; i++) begin
         n = $urandom_range(0, 4);
         by = $urandom;
         hw = 8'($urandom);
         drive_frame(n, by, hw);
         model_frame(n, by, hw, es, ee);
         check($sformatf("rnd%0d_tx", i), tx_data, m_tx);
         check($sformatf("rnd%0d_strobes", i), strobe_cnt, es);
         check($sformatf("rnd%0d_errs", i), err_cnt, ee);
         check($sformatf("rnd%0d_regs", i), regs, model_vec());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
